cla_resp_checker: RTL

- Synthesizable response checker: the receiving end of the adder stimulus stream.
- Samples each applied vector (a, b, cin) and the adder-under-test result (s, cout), then compares the result against an internal reference sum.
- Counts vectors and mismatches and captures the first failing vector.
- Sits beside the carry look-ahead adder in self-test builds; its done/pass flags replace manual inspection of monitor output.

---
 rtl/cla_chk_defs_pkg.sv | 15 +
 rtl/cla_ref_add.sv | 15 +
 rtl/cla_resp_checker.sv | 127 ++++++++++++
 3 files changed

// File: rtl/cla_chk_defs_pkg.sv
// Shared definitions for the adder self-test checker and its stimulus side:
// default sweep dimensions and the checker FSM state encoding.
package cla_chk_defs;

    localparam int DEF_WIDTH       = 3;
    localparam int DEF_NUM_VECTORS = 128;
    localparam int DEF_CW          = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cla_ref_add.sv
// Combinational reference adder: returns {cout,s} = a + b + cin at WIDTH+1 bits.
module cla_ref_add
    import cla_chk_defs::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH:0]   sum
);

    assign sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/cla_resp_checker.sv
// Response checker for the adder self-test: compares each accepted vector against
// the reference sum, counts vectors/mismatches and captures the first failure.
module cla_resp_checker
    import cla_chk_defs::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int NUM_VECTORS = DEF_NUM_VECTORS,
    parameter int CW          = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cin,
    input  logic [WIDTH-1:0]     s,
    input  logic                 cout,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CW-1:0]        vec_count,
    output logic [CW-1:0]        err_count,
    output logic                 first_err_valid,
    output logic [CW-1:0]        first_err_idx,
    output logic [2*WIDTH:0]     first_err_vec,
    output logic [WIDTH:0]       first_err_got
);

    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_VECTORS - 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       vec_count_q, vec_count_d;
    logic [CW-1:0]       err_count_q, err_count_d;
    logic                first_err_valid_q, first_err_valid_d;
    logic [CW-1:0]       first_err_idx_q, first_err_idx_d;
    logic [2*WIDTH:0]    first_err_vec_q, first_err_vec_d;
    logic [WIDTH:0]      first_err_got_q, first_err_got_d;

    logic [WIDTH:0]      ref_sum;
    logic                mismatch;

    cla_ref_add #(.WIDTH(WIDTH)) u_ref (
        .a   (a),
        .b   (b),
        .cin (cin),
        .sum (ref_sum)
    );

    assign mismatch = ({cout, s} != ref_sum);

    always_comb begin
        state_d           = state_q;
        vec_count_d       = vec_count_q;
        err_count_d       = err_count_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_got_d   = first_err_got_q;

        case (state_q)
            ST_RUN: begin
                // start is deliberately ignored while a run is in progress
                if (in_valid) begin
                    vec_count_d = vec_count_q + 1'b1;
                    if (mismatch) begin
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + 1'b1;
                        end
                        if (!first_err_valid_q) begin
                            first_err_valid_d = 1'b1;
                            first_err_idx_d   = vec_count_q;
                            first_err_vec_d   = {a, b, cin};
                            first_err_got_d   = {cout, s};
                        end
                    end
                    if (vec_count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                // IDLE and DONE both launch a fresh run on start
                if (start) begin
                    state_d           = ST_RUN;
                    vec_count_d       = '0;
                    err_count_d       = '0;
                    first_err_valid_d = 1'b0;
                    first_err_idx_d   = '0;
                    first_err_vec_d   = '0;
                    first_err_got_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            vec_count_q       <= '0;
            err_count_q       <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
            first_err_vec_q   <= '0;
            first_err_got_q   <= '0;
        end else begin
            state_q           <= state_d;
            vec_count_q       <= vec_count_d;
            err_count_q       <= err_count_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_got_q   <= first_err_got_d;
        end
    end

    assign busy            = (state_q == ST_RUN);
    assign done            = (state_q == ST_DONE);
    assign pass            = done && (err_count_q == '0);
    assign vec_count       = vec_count_q;
    assign err_count       = err_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_idx   = first_err_idx_q;
    assign first_err_vec   = first_err_vec_q;
    assign first_err_got   = first_err_got_q;

endmodule
